// File: rtl/i2s_mic_rx_stream.sv
// I2S master receiver for MEMS microphones: generates SCK/WS, deserialises slots
// and queues channel-tagged samples in a small valid/ready FIFO with a sticky overrun flag.
module i2s_mic_rx_stream #(
  parameter int unsigned SCK_DIV_LOG2 = 3,
  parameter int unsigned SLOT_BITS    = 32,
  parameter int unsigned DATA_W       = 24,
  parameter bit          STEREO       = 1'b0,
  parameter bit          LR_SEL       = 1'b0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              lr,
  output logic              sck,
  output logic              ws,
  input  logic              sd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int unsigned DW = SCK_DIV_LOG2 + 1;
  localparam int unsigned BW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [DW-1:0] D_RISE  = DW'((1 << SCK_DIV_LOG2) - 1);
  localparam logic [DW-1:0] D_LAST  = '1;
  localparam logic [BW-1:0] B_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] B_MSB   = BW'(DATA_W);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic              chan;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DW-1:0]     d_q;
  logic [DW-1:0]     d_next;
  logic [BW-1:0]     b_q;
  logic [DATA_W-1:0] shift_q;
  logic              slot_valid_q;
  logic              d_wrap;
  logic              slot_end;
  logic              sample_now;
  logic              in_window;
  logic              push;

  assign lr         = LR_SEL;
  assign d_next     = d_q + 1'b1;
  assign d_wrap     = (d_q == D_LAST);
  assign slot_end   = enable && d_wrap && (b_q == B_LAST);
  assign sample_now = enable && (d_q == D_RISE);
  // Bit 0 of each slot is the I2S one-bit delay; bits past DATA_W are padding.
  assign in_window  = (b_q != '0) && (b_q <= B_MSB);
  assign push       = slot_end && slot_valid_q && (STEREO || (ws == LR_SEL));

  // NOTE: every register below is written with <= so all flops see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q          <= '0;
      b_q          <= '0;
      sck          <= 1'b0;
      ws           <= 1'b1;
      shift_q      <= '0;
      slot_valid_q <= 1'b0;
    end else if (!enable) begin
      d_q          <= '0;
      b_q          <= '0;
      sck          <= 1'b0;
      ws           <= 1'b1;
      shift_q      <= '0;
      slot_valid_q <= 1'b0;
    end else begin
      d_q <= d_next;
      // P is a power of two, so d >= P is exactly the divider MSB.
      sck <= d_next[DW-1];
      if (d_wrap) begin
        b_q <= (b_q == B_LAST) ? '0 : b_q + 1'b1;
      end
      if (sample_now && in_window) begin
        shift_q <= (shift_q << 1) | DATA_W'(sd);
      end
      if (slot_end) begin
        ws           <= ~ws;
        slot_valid_q <= 1'b1;
      end
    end
  end

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          accept;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign accept    = push && ((count < DEPTH_C) || pop);
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head.data : '0;
  assign out_chan  = out_valid ? head.chan : 1'b0;

  // NOTE: the storage array has no reset; its contents are masked until count says valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= '{chan: ws, data: shift_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear wins, so no loss goes unreported.
      if (push && !accept) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
